ui_entry_rom_fetcher: RTL and testbench

Responder side of the UI-timeline sync/update handshake. Given an entry index `addr` and a low `sync_ui_time` from the UI runtime, it fetches a multi-word UI entry from a synchronous ROM port and unpacks it into registered field outputs. It then raises `update_ui_time` and holds it until the runtime acknowledges. It sits between the timeline BRAM and the runtime, on the calculation clock.

---
 rtl/ui_entry_rom_fetcher_if.sv | 21 ++
 rtl/ui_entry_rom_fetcher.sv | 199 +++++++++++++++++++
 tb/tb_ui_entry_rom_fetcher.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ui_entry_rom_fetcher_if.sv
// ROM read port between the entry fetcher and the timeline BRAM.
// Read data is valid on the cycle after rom_en.
interface ui_entry_rom_fetcher_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  rom_en;
    logic [ADDR_WIDTH+2:0] rom_addr;
    logic [31:0]           rom_data;

    modport master (
        output rom_en,
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_en,
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/ui_entry_rom_fetcher.sv
// Fetches a five-word UI entry from ROM, unpacks it into registered fields
// and holds update_ui_time until the UI runtime acknowledges.
module ui_entry_rom_fetcher #(
    parameter int ADDR_WIDTH    = 10,
    parameter int MAXIMUM_TIMES = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic                     sync_ui_time,
    output logic                     update_ui_time,
    output logic                     busy,
    ui_entry_rom_fetcher_if.master   rom,
    output logic [9:0]               healt_current,
    output logic [9:0]               healt_max,
    output logic [9:0]               character_amount,
    output logic [9:0]               healt_bar_pos_x,
    output logic [9:0]               healt_bar_pos_y,
    output logic [9:0]               healt_bar_w,
    output logic [9:0]               healt_bar_h,
    output logic [6:0]               healt_bar_sensitivity,
    output logic [15:0]              wait_time,
    output logic [MAXIMUM_TIMES-1:0] next_ui_time,
    output logic                     transparent_out_screen_display,
    output logic                     reset_when_dead,
    output logic                     is_end
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic                     is_end;
        logic                     transparent;
        logic                     reset_when_dead;
        logic [6:0]               sensitivity;
        logic [9:0]               hp_max;
        logic [9:0]               hp_cur;
        logic [9:0]               chars;
        logic [9:0]               pos_y;
        logic [9:0]               pos_x;
        logic [9:0]               bar_h;
        logic [9:0]               bar_w;
        logic [MAXIMUM_TIMES-1:0] next_time;
        logic [15:0]              wait_t;
    } fields_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  cap_vld_q, cap_vld_d;
    logic [2:0]            cap_idx_q, cap_idx_d;
    fields_t               shadow_q, shadow_d;
    fields_t               out_q, out_d;
    logic                  end_hit;

    // w0 arrives on the edge after its issue; an end marker aborts the rest.
    assign end_hit = (state_q == S_FETCH) && cap_vld_q &&
                     (cap_idx_q == 3'd0) && rom.rom_data[31];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!sync_ui_time) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (end_hit) begin
                    state_d = S_HOLD;
                end else if (cnt_q == 3'd4) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (sync_ui_time) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rom.rom_en     = (state_q == S_FETCH);
        rom.rom_addr   = rom.rom_en ? {addr_q, cnt_q} : '0;
        busy           = (state_q == S_FETCH) || (state_q == S_DRAIN);
        update_ui_time = (state_q == S_HOLD);
    end

    always_comb begin
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        cap_vld_d = 1'b0;
        cap_idx_d = cnt_q;
        shadow_d  = shadow_q;
        out_d     = out_q;

        if ((state_q == S_IDLE) && !sync_ui_time) begin
            addr_d = addr;
            cnt_d  = 3'd0;
        end

        if (state_q == S_FETCH) begin
            cnt_d     = cnt_q + 3'd1;
            cap_vld_d = !end_hit;
        end

        if (cap_vld_q) begin
            unique case (cap_idx_q)
                3'd0: begin
                    shadow_d.transparent     = rom.rom_data[30];
                    shadow_d.reset_when_dead = rom.rom_data[29];
                    shadow_d.sensitivity     = rom.rom_data[26:20];
                    shadow_d.hp_max          = rom.rom_data[19:10];
                    shadow_d.hp_cur          = rom.rom_data[9:0];
                end
                3'd1: begin
                    shadow_d.chars = rom.rom_data[29:20];
                    shadow_d.pos_y = rom.rom_data[19:10];
                    shadow_d.pos_x = rom.rom_data[9:0];
                end
                3'd2: begin
                    shadow_d.bar_h = rom.rom_data[19:10];
                    shadow_d.bar_w = rom.rom_data[9:0];
                end
                3'd3: begin
                    shadow_d.next_time = rom.rom_data[MAXIMUM_TIMES-1:0];
                end
                3'd4: begin
                    shadow_d.wait_t = rom.rom_data[15:0];
                end
                default: begin
                end
            endcase
        end

        // w4 lands in shadow_d on the same edge the whole entry commits.
        if (state_q == S_DRAIN) begin
            out_d        = shadow_d;
            out_d.is_end = 1'b0;
        end

        if (end_hit) begin
            out_d.is_end = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            shadow_q  <= '0;
            out_q     <= '0;
        end else begin
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
            shadow_q  <= shadow_d;
            out_q     <= out_d;
        end
    end

    assign healt_current                  = out_q.hp_cur;
    assign healt_max                      = out_q.hp_max;
    assign character_amount               = out_q.chars;
    assign healt_bar_pos_x                = out_q.pos_x;
    assign healt_bar_pos_y                = out_q.pos_y;
    assign healt_bar_w                    = out_q.bar_w;
    assign healt_bar_h                    = out_q.bar_h;
    assign healt_bar_sensitivity          = out_q.sensitivity;
    assign wait_time                      = out_q.wait_t;
    assign next_ui_time                   = out_q.next_time;
    assign transparent_out_screen_display = out_q.transparent;
    assign reset_when_dead                = out_q.reset_when_dead;
    assign is_end                         = out_q.is_end;

endmodule

// File: tb/tb_ui_entry_rom_fetcher.sv
// Directed bench for ui_entry_rom_fetcher with a transaction-level model
// and a per-cycle compare process.
module tb_ui_entry_rom_fetcher;

    localparam int AW = 10;
    localparam int MT = 30;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          sync_ui_time = 1'b1;
    logic          update_ui_time, busy;
    logic [9:0]    healt_current, healt_max, character_amount;
    logic [9:0]    healt_bar_pos_x, healt_bar_pos_y, healt_bar_w, healt_bar_h;
    logic [6:0]    healt_bar_sensitivity;
    logic [15:0]   wait_time;
    logic [MT-1:0] next_ui_time;
    logic          transparent_out_screen_display, reset_when_dead, is_end;

    ui_entry_rom_fetcher_if #(.ADDR_WIDTH(AW)) rom_if ();

    ui_entry_rom_fetcher #(.ADDR_WIDTH(AW), .MAXIMUM_TIMES(MT)) dut (
        .clk                            (clk),
        .reset                          (reset),
        .addr                           (addr),
        .sync_ui_time                   (sync_ui_time),
        .update_ui_time                 (update_ui_time),
        .busy                           (busy),
        .rom                            (rom_if),
        .healt_current                  (healt_current),
        .healt_max                      (healt_max),
        .character_amount               (character_amount),
        .healt_bar_pos_x                (healt_bar_pos_x),
        .healt_bar_pos_y                (healt_bar_pos_y),
        .healt_bar_w                    (healt_bar_w),
        .healt_bar_h                    (healt_bar_h),
        .healt_bar_sensitivity          (healt_bar_sensitivity),
        .wait_time                      (wait_time),
        .next_ui_time                   (next_ui_time),
        .transparent_out_screen_display (transparent_out_screen_display),
        .reset_when_dead                (reset_when_dead),
        .is_end                         (is_end)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:8191];

    // synchronous ROM; filler data when not enabled
    always @(posedge clk)
        rom_if.rom_data <= rom_if.rom_en ? mem[rom_if.rom_addr] : 32'hA5A5_A5A5;

    int n_cmp = 0;
    int n_bad = 0;
    int en_cnt = 0;
    int en_base;

    always @(posedge clk) if (rom_if.rom_en) en_cnt++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: 0 idle, 1 fetching (m_j edges since request), 2 holding
    int            m_mode = 0;
    int            m_j = 0;
    int unsigned   m_base = 0;
    int unsigned   w0, w1, w2, w3, w4;
    logic [9:0]    e_hcur = '0, e_hmax = '0, e_chr = '0;
    logic [9:0]    e_px = '0, e_py = '0, e_bw = '0, e_bh = '0;
    logic [6:0]    e_sens = '0;
    logic [15:0]   e_wt = '0;
    logic [MT-1:0] e_nxt = '0;
    logic          e_tr = 1'b0, e_rwd = 1'b0, e_ie = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_j = 0; m_base = 0;
            e_hcur = '0; e_hmax = '0; e_chr = '0;
            e_px = '0; e_py = '0; e_bw = '0; e_bh = '0;
            e_sens = '0; e_wt = '0; e_nxt = '0;
            e_tr = 1'b0; e_rwd = 1'b0; e_ie = 1'b0;
        end else if (m_mode == 0) begin
            if (!sync_ui_time) begin
                m_mode = 1;
                m_j = 0;
                m_base = 8 * int'(addr);
            end
        end else if (m_mode == 1) begin
            m_j++;
            w0 = mem[m_base];
            if (m_j == 2 && w0 >= 32'h8000_0000) begin
                e_ie = 1'b1;
                m_mode = 2;
            end else if (m_j == 6) begin
                w1 = mem[m_base + 1];
                w2 = mem[m_base + 2];
                w3 = mem[m_base + 3];
                w4 = mem[m_base + 4];
                e_hcur = 10'(w0 % 1024);
                e_hmax = 10'((w0 / 1024) % 1024);
                e_sens = 7'((w0 / (1 << 20)) % 128);
                e_rwd  = 1'((w0 / (1 << 29)) % 2);
                e_tr   = 1'((w0 / (1 << 30)) % 2);
                e_px   = 10'(w1 % 1024);
                e_py   = 10'((w1 / 1024) % 1024);
                e_chr  = 10'((w1 / (1 << 20)) % 1024);
                e_bw   = 10'(w2 % 1024);
                e_bh   = 10'((w2 / 1024) % 1024);
                e_nxt  = MT'(w3 % (32'd1 << MT));
                e_wt   = 16'(w4 % 65536);
                e_ie   = 1'b0;
                m_mode = 2;
            end
        end else if (sync_ui_time) begin
            m_mode = 0;
        end
    end

    always @(posedge clk) begin
        logic        e_en;
        int unsigned e_addr;
        #1;
        e_en   = (m_mode == 1) && (m_j <= 4);
        e_addr = e_en ? m_base + m_j : 0;
        chk("update", 32'(update_ui_time), 32'(m_mode == 2));
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("rom_en", 32'(rom_if.rom_en), 32'(e_en));
        chk("rom_addr", 32'(rom_if.rom_addr), e_addr);
        chk("hcur", 32'(healt_current), 32'(e_hcur));
        chk("hmax", 32'(healt_max), 32'(e_hmax));
        chk("chars", 32'(character_amount), 32'(e_chr));
        chk("pos_x", 32'(healt_bar_pos_x), 32'(e_px));
        chk("pos_y", 32'(healt_bar_pos_y), 32'(e_py));
        chk("bar_w", 32'(healt_bar_w), 32'(e_bw));
        chk("bar_h", 32'(healt_bar_h), 32'(e_bh));
        chk("sens", 32'(healt_bar_sensitivity), 32'(e_sens));
        chk("wait", 32'(wait_time), 32'(e_wt));
        chk("next", 32'(next_ui_time), 32'(e_nxt));
        chk("transp", 32'(transparent_out_screen_display), 32'(e_tr));
        chk("rwd", 32'(reset_when_dead), 32'(e_rwd));
        chk("is_end", 32'(is_end), 32'(e_ie));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_update"}, 32'(update_ui_time), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rom_en"}, 32'(rom_if.rom_en), 0);
        chk({tag, "_rom_addr"}, 32'(rom_if.rom_addr), 0);
        chk({tag, "_is_end"}, 32'(is_end), 0);
        chk({tag, "_hcur"}, 32'(healt_current), 0);
        chk({tag, "_hmax"}, 32'(healt_max), 0);
        chk({tag, "_next"}, 32'(next_ui_time), 0);
        chk({tag, "_wait"}, 32'(wait_time), 0);
        chk({tag, "_rwd"}, 32'(reset_when_dead), 0);
    endtask

    task automatic chk_entry3(input string tag);
        chk({tag, "_hcur"}, 32'(healt_current), 100);
        chk({tag, "_hmax"}, 32'(healt_max), 74);
        chk({tag, "_sens"}, 32'(healt_bar_sensitivity), 1);
        chk({tag, "_transp"}, 32'(transparent_out_screen_display), 0);
        chk({tag, "_rwd"}, 32'(reset_when_dead), 1);
        chk({tag, "_pos_x"}, 32'(healt_bar_pos_x), 20);
        chk({tag, "_pos_y"}, 32'(healt_bar_pos_y), 25);
        chk({tag, "_chars"}, 32'(character_amount), 5);
        chk({tag, "_bar_w"}, 32'(healt_bar_w), 120);
        chk({tag, "_bar_h"}, 32'(healt_bar_h), 10);
        chk({tag, "_next"}, 32'(next_ui_time), 500);
        chk({tag, "_wait"}, 32'(wait_time), 50);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        mem[24] = 32'h2011_2864;
        mem[25] = 32'h0050_6414;
        mem[26] = 32'h0000_2878;
        mem[27] = 32'h0000_01F4;
        mem[28] = 32'h0000_0032;
        mem[32] = 32'h8000_0000;
        mem[33] = 32'h3FFF_FFFF;
        mem[34] = 32'h0000_0123;
        mem[56] = 32'h7FFF_FFFF;
        mem[57] = 32'hFFFF_FFFF;
        mem[58] = 32'hFFFF_FFFF;
        mem[59] = 32'hFFFF_FFFF;
        mem[60] = 32'hFFFF_FFFF;

        repeat (3) tick();
        chk_all_zero("reset");

        // entry 3: full fetch
        reset = 1'b1; sync_ui_time = 1'b0; addr = 10'd3;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("e3_rom_en", 32'(rom_if.rom_en), 1);
            chk("e3_rom_addr", 32'(rom_if.rom_addr), 32'(24 + k));
            chk("e3_no_update", 32'(update_ui_time), 0);
            tick();
        end
        chk("e3_drain_busy", 32'(busy), 1);
        chk("e3_drain_update", 32'(update_ui_time), 0);
        tick();
        chk("e3_update", 32'(update_ui_time), 1);
        chk("e3_busy", 32'(busy), 0);
        chk("e3_is_end", 32'(is_end), 0);
        chk_entry3("e3");
        repeat (20) begin
            tick();
            chk("hold_update", 32'(update_ui_time), 1);
            chk("hold_rom_en", 32'(rom_if.rom_en), 0);
        end
        chk_entry3("hold");
        sync_ui_time = 1'b1;
        tick();
        chk("ack_update", 32'(update_ui_time), 0);

        // entry 4: end marker aborts after w0
        en_base = en_cnt;
        addr = 10'd4; sync_ui_time = 1'b0;
        tick();
        chk("end_addr0", 32'(rom_if.rom_addr), 32);
        tick();
        chk("end_addr1", 32'(rom_if.rom_addr), 33);
        tick();
        chk("end_is_end", 32'(is_end), 1);
        chk("end_update", 32'(update_ui_time), 1);
        chk("end_rom_en", 32'(rom_if.rom_en), 0);
        chk_entry3("end_keep");
        repeat (3) tick();
        chk("end_pulses", 32'(en_cnt - en_base), 2);

        // ack then immediate re-request
        sync_ui_time = 1'b1;
        tick();
        chk("b2b_ack", 32'(update_ui_time), 0);
        sync_ui_time = 1'b0; addr = 10'd4;
        tick();
        chk("b2b_rom_en", 32'(rom_if.rom_en), 1);
        chk("b2b_rom_addr", 32'(rom_if.rom_addr), 32);
        tick(); tick();
        chk("b2b_is_end", 32'(is_end), 1);
        sync_ui_time = 1'b1;
        tick();

        // addr moves mid-fetch
        sync_ui_time = 1'b0; addr = 10'd3;
        tick(); tick(); tick();
        addr = 10'd7;
        tick();
        chk("chg_rom_addr", 32'(rom_if.rom_addr), 27);
        tick(); tick(); tick();
        chk("chg_update", 32'(update_ui_time), 1);
        chk("chg_is_end", 32'(is_end), 0);
        chk_entry3("chg");
        sync_ui_time = 1'b1;
        tick();

        // entry 7: all-ones words, upper w3 bits dropped
        sync_ui_time = 1'b0; addr = 10'd7;
        repeat (7) tick();
        chk("e7_next", 32'(next_ui_time), 32'h3FFF_FFFF);
        chk("e7_wait", 32'(wait_time), 32'hFFFF);
        chk("e7_hcur", 32'(healt_current), 1023);
        chk("e7_sens", 32'(healt_bar_sensitivity), 127);
        chk("e7_chars", 32'(character_amount), 1023);
        chk("e7_transp", 32'(transparent_out_screen_display), 1);
        chk("e7_is_end", 32'(is_end), 0);
        sync_ui_time = 1'b1;
        tick();

        // reset in the middle of a fetch
        sync_ui_time = 1'b0; addr = 10'd3;
        repeat (4) tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (2) tick();
        chk_all_zero("midrst_hold");
        reset = 1'b1;
        tick();
        chk("restart_rom_addr", 32'(rom_if.rom_addr), 24);
        repeat (6) tick();
        chk("restart_update", 32'(update_ui_time), 1);
        chk_entry3("restart");
        sync_ui_time = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
